// File: rtl/system_top.sv
// Hard-decision Viterbi decoder, K=3 rate-1/2 (G1=7, G0=5): one 16-bit frame in, one decoded byte out.
// Optional macro VITERBI_PM_OUT_EN adds pm_o, the winning path metric (number of corrected channel-bit errors).
module system_top #(
    parameter int TBL      = 15,
    parameter int PM_WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                dvalid_i,
    input  logic [15:0]         data_i,
    output logic [7:0]          data_o,
    output logic                valid_o,
    output logic                busy_o
`ifdef VITERBI_PM_OUT_EN
    ,
    output logic [PM_WIDTH-1:0] pm_o
`endif
);

    localparam int AW = (TBL > 1) ? $clog2(TBL) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ACS,
        S_SELECT,
        S_TRACE,
        S_OUT
    } state_t;

    state_t              r_state;
    state_t              w_nextState;
    logic [15:0]         r_piso;
    logic [2:0]          r_step;
    logic [PM_WIDTH-1:0] r_pathMetric [4];
    logic [3:0]          r_survivor [TBL];
    logic [1:0]          r_traceState;
    logic [7:0]          r_decoded;
    logic [7:0]          r_dataOut;
`ifdef VITERBI_PM_OUT_EN
    logic [PM_WIDTH-1:0] r_bestMetric;
    logic [PM_WIDTH-1:0] r_pmOut;
`endif

    logic [1:0]          w_symbol;
    logic [PM_WIDTH-1:0] w_newMetric [4];
    logic [3:0]          w_decision;
    logic [1:0]          w_bestState;
    logic [PM_WIDTH-1:0] w_bestMetric;
    logic [AW-1:0]       w_survAddr;
    logic [3:0]          w_survRead;

    function automatic logic [PM_WIDTH-1:0] satAdd(input logic [PM_WIDTH-1:0] a, input logic [1:0] b);
        logic [PM_WIDTH:0] sum;
        sum = {1'b0, a} + {{(PM_WIDTH-1){1'b0}}, b};
        return sum[PM_WIDTH] ? {PM_WIDTH{1'b1}} : sum[PM_WIDTH-1:0];
    endfunction

    // Hamming distance between the received pair and what the encoder emits leaving 'pred' with input 'b'.
    function automatic logic [1:0] branchMetric(input logic [1:0] rx, input logic [1:0] pred, input logic b);
        logic [1:0] diff;
        diff = rx ^ {b ^ pred[1] ^ pred[0], b ^ pred[0]};
        return {1'b0, diff[1]} + {1'b0, diff[0]};
    endfunction

    assign w_symbol   = r_piso[15:14];
    assign w_survAddr = AW'(r_step);
    assign w_survRead = r_survivor[w_survAddr];

    // State n={b,s1} is reached from {s1,0} or {s1,1}; the decision bit records which (0 wins ties).
    for (genvar g = 0; g < 4; g++) begin : g_acs
        localparam logic [1:0] P0 = 2'((g % 2) * 2);
        localparam logic [1:0] P1 = 2'((g % 2) * 2 + 1);
        localparam logic       B  = (g >= 2);
        logic [PM_WIDTH-1:0] w_cand0;
        logic [PM_WIDTH-1:0] w_cand1;
        assign w_cand0        = satAdd(r_pathMetric[P0], branchMetric(w_symbol, P0, B));
        assign w_cand1        = satAdd(r_pathMetric[P1], branchMetric(w_symbol, P1, B));
        assign w_decision[g]  = (w_cand1 < w_cand0);
        assign w_newMetric[g] = w_decision[g] ? w_cand1 : w_cand0;
    end

    always_comb begin
        w_bestState  = 2'd0;
        w_bestMetric = r_pathMetric[0];
        for (int s = 1; s < 4; s++) begin
            if (r_pathMetric[s] < w_bestMetric) begin
                w_bestMetric = r_pathMetric[s];
                w_bestState  = 2'(s);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            S_IDLE:   if (dvalid_i) w_nextState = S_LOAD;
            S_LOAD:   w_nextState = S_ACS;
            S_ACS:    if (r_step == 3'd7) w_nextState = S_SELECT;
            S_SELECT: w_nextState = S_TRACE;
            S_TRACE:  if (r_step == 3'd0) w_nextState = S_OUT;
            S_OUT:    w_nextState = S_IDLE;
            default:  w_nextState = S_IDLE;
        endcase
    end

    always_comb begin
        valid_o = (r_state == S_OUT);
        busy_o  = (r_state != S_IDLE);
        data_o  = r_dataOut;
`ifdef VITERBI_PM_OUT_EN
        pm_o    = r_pmOut;
`endif
    end

    always_ff @(posedge clk) begin
        if (r_state == S_ACS) begin
            r_survivor[w_survAddr] <= w_decision;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_piso       <= '0;
            r_step       <= '0;
            r_traceState <= '0;
            r_decoded    <= '0;
            r_dataOut    <= '0;
            for (int s = 0; s < 4; s++) r_pathMetric[s] <= '0;
`ifdef VITERBI_PM_OUT_EN
            r_bestMetric <= '0;
            r_pmOut      <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (dvalid_i) r_piso <= data_i;
                end
                S_LOAD: begin
                    r_step          <= 3'd0;
                    r_pathMetric[0] <= '0;
                    for (int s = 1; s < 4; s++) r_pathMetric[s] <= {PM_WIDTH{1'b1}};
                end
                S_ACS: begin
                    for (int s = 0; s < 4; s++) r_pathMetric[s] <= w_newMetric[s];
                    r_piso <= {r_piso[13:0], 2'b00};
                    r_step <= r_step + 3'd1;
                end
                S_SELECT: begin
                    r_traceState <= w_bestState;
                    r_step       <= 3'd7;
`ifdef VITERBI_PM_OUT_EN
                    r_bestMetric <= w_bestMetric;
`endif
                end
                S_TRACE: begin
                    // Step t yields the input bit of time t, which lands in byte position 7-t.
                    r_decoded[~r_step] <= r_traceState[1];
                    r_traceState       <= {r_traceState[0], w_survRead[r_traceState]};
                    r_step             <= r_step - 3'd1;
                    if (r_step == 3'd0) begin
                        r_dataOut <= {r_traceState[1], r_decoded[6:0]};
`ifdef VITERBI_PM_OUT_EN
                        r_pmOut   <= r_bestMetric;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_system_top.sv
// Directed bench for system_top: reset, latency, clean/corrupted frames, busy-time strobes, mid-frame reset.
module tb_system_top;

    logic        clk;
    logic        rst_n;
    logic        dvalid_i;
    logic [15:0] data_i;
    logic [7:0]  data_o;
    logic        valid_o;
    logic        busy_o;
`ifdef VITERBI_PM_OUT_EN
    logic [7:0]  pm_o;
`endif

    int checkCount = 0;
    int passCount  = 0;
    int failCount  = 0;
    int validCount = 0;

    system_top #(.TBL(15), .PM_WIDTH(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .dvalid_i (dvalid_i),
        .data_i   (data_i),
        .data_o   (data_o),
        .valid_o  (valid_o),
        .busy_o   (busy_o)
`ifdef VITERBI_PM_OUT_EN
        ,
        .pm_o     (pm_o)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (valid_o === 1'b1) validCount++;
    end

    // Reference K=3 encoder starting from state 00, first data bit taken from d[7].
    function automatic logic [15:0] encodeByte(input logic [7:0] d);
        logic        s1;
        logic        s0;
        logic        b;
        logic [15:0] e;
        s1 = 1'b0;
        s0 = 1'b0;
        e  = '0;
        for (int k = 0; k < 8; k++) begin
            b           = d[7-k];
            e[15-2*k]   = b ^ s1 ^ s0;
            e[14-2*k]   = b ^ s0;
            s0          = s1;
            s1          = b;
        end
        return e;
    endfunction

    task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        checkCount++;
        assert (observed === expected) begin
            passCount++;
        end else begin
            failCount++;
            $error("[TB] FAIL %s: observed 0x%h required 0x%h", tag, observed, expected);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [15:0] frame);
        dvalid_i = 1'b1;
        data_i   = frame;
        tick(1);
        dvalid_i = 1'b0;
        data_i   = '0;
    endtask

    // Cycle number (strobe cycle = 0) at which valid_o is observed; 60 means it never came.
    task automatic waitValid(output int latency);
        latency = 1;
        while (valid_o !== 1'b1 && latency < 60) begin
            tick(1);
            latency++;
        end
    endtask

    task automatic runFrame(input string tag, input logic [15:0] frame, input logic [7:0] expData,
                            input logic [7:0] expPm);
        int lat;
        int startCount;
        startCount = validCount;
        applyStimulus(frame);
        waitValid(lat);
        checkOutput({tag, "_latency"}, 16'(lat), 16'd19);
        checkOutput({tag, "_data"}, 16'(data_o), 16'(expData));
`ifdef VITERBI_PM_OUT_EN
        checkOutput({tag, "_pm"}, 16'(pm_o), 16'(expPm));
`else
        if (expPm != 8'd0) $display("[TB] note: %s carries corrected errors, pm_o not built", tag);
`endif
        tick(1);
        checkOutput({tag, "_busyAfter"}, 16'(busy_o), 16'd0);
        checkOutput({tag, "_pulses"}, 16'(validCount - startCount), 16'd1);
    endtask

    initial begin
        int          lat;
        int          startCount;
        logic [7:0]  randByte;

        rst_n    = 1'b1;
        dvalid_i = 1'b0;
        data_i   = '0;
        tick(10);
        rst_n = 1'b0;
        checkOutput("reset_data", 16'(data_o), 16'h0000);
        checkOutput("reset_valid", 16'(valid_o), 16'd0);
        checkOutput("reset_busy", 16'(busy_o), 16'd0);
        tick(1);

        runFrame("zero", 16'h0000, 8'h00, 8'd0);
        runFrame("enc55", 16'h3888, 8'h55, 8'd0);
        runFrame("encFF", 16'hDAAA, 8'hFF, 8'd0);

        runFrame("seq55", encodeByte(8'h55), 8'h55, 8'd0);
        runFrame("seqAB", encodeByte(8'hAB), 8'hAB, 8'd0);
        for (int i = 0; i < 5; i++) begin
            randByte = 8'($urandom_range(255, 0));
            $display("[TB] random frame %0d byte 0x%h", i, randByte);
            runFrame("rand", encodeByte(randByte), randByte, 8'd0);
        end

        runFrame("err15", 16'hB888, 8'h55, 8'd1);
        runFrame("errZero", 16'h1000, 8'h00, 8'd1);

        // Strobe while busy must be dropped.
        startCount = validCount;
        applyStimulus(16'h3888);
        tick(3);
        checkOutput("busyDuringFrame", 16'(busy_o), 16'd1);
        dvalid_i = 1'b1;
        data_i   = 16'hDAAA;
        tick(1);
        dvalid_i = 1'b0;
        data_i   = '0;
        waitValid(lat);
        checkOutput("ignore_data", 16'(data_o), 16'h0055);
        tick(30);
        checkOutput("ignore_pulses", 16'(validCount - startCount), 16'd1);
        checkOutput("ignore_idle", 16'(busy_o), 16'd0);

        // Strobe held for several cycles starts a single frame.
        startCount = validCount;
        dvalid_i = 1'b1;
        data_i   = 16'hDAAA;
        tick(4);
        dvalid_i = 1'b0;
        data_i   = '0;
        waitValid(lat);
        checkOutput("held_data", 16'(data_o), 16'h00FF);
        tick(30);
        checkOutput("held_pulses", 16'(validCount - startCount), 16'd1);

        // Reset five cycles into a frame drops it.
        startCount = validCount;
        applyStimulus(16'hDAAA);
        tick(4);
        rst_n = 1'b1;
        tick(1);
        rst_n = 1'b0;
        checkOutput("midReset_busy", 16'(busy_o), 16'd0);
        checkOutput("midReset_valid", 16'(valid_o), 16'd0);
        checkOutput("midReset_data", 16'(data_o), 16'h0000);
        tick(30);
        checkOutput("midReset_pulses", 16'(validCount - startCount), 16'd0);
        runFrame("afterReset", 16'h3888, 8'h55, 8'd0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/system_top.md
Name: system_top

Overview:
Hard-decision Viterbi decoder subsystem for a K=3, rate-1/2 convolutional code (generators G1=7 octal (111), G0=5 octal (101)). It accepts one 16-bit encoded frame (8 symbol pairs) per request, serializes the symbols into an add-compare-select core, and runs a traceback. It returns the 8 decoded data bits as one byte. It sits between a word-wide encoded-data source and a byte-wide sink.

Parameters:
TBL, 15, survivor-memory depth in symbols; must be >= 8. Only the 8 most recent entries are used per frame.
PM_WIDTH, 8, path-metric register width in bits. Metrics saturate at 2^PM_WIDTH-1.

Ports:
clk  in  1  single system clock, rising edge.
rst_n  in  1  reset; synchronous, active-high (asserted when 1), despite the _n suffix.
dvalid_i  in  1  single-cycle frame strobe; honoured only when busy_o=0.
data_i  in  16  encoded frame. Symbol k (k=0 first, k=0..7) is data_i[15-2k:14-2k], with the upper bit = G1 output and the lower bit = G0 output.
data_o  out  8  decoded byte; first decoded bit in data_o[7]. Held until the next result.
valid_o  out  1  one-cycle pulse marking a new data_o.
busy_o  out  1  high while a frame is in flight.

Behaviour:
- Reset (rst_n=1 at a clk edge):
  - data_o=0, valid_o=0, busy_o=0.
  - FSM goes to IDLE, all path metrics are cleared, and any in-flight frame is dropped.
- Encoder model, used for decoding:
  - State s={s1,s0}. For input bit b: G1=b^s1^s0, G0=b^s0, next state={b,s1}.
  - Every frame starts in state 00. Frames are independent and not terminated.
- FSM states: IDLE, LOAD, ACS, SELECT, TRACE, OUT.
  - IDLE: dvalid_i=1 captures data_i into the PISO. Next cycle: LOAD, busy_o=1.
  - LOAD: initialize metrics. State 00 = 0; all other states = saturated max.
  - ACS: 8 cycles, one symbol per cycle, MSB pair first.
    - Branch metric = Hamming distance (0..2) between the received symbol and the expected G1G0.
    - New metric = min over the two predecessors of (old + branch), saturating add.
    - Tie: choose the predecessor with the lower state index.
    - Store one decision bit per state per step in the survivor memory.
  - SELECT: 1 cycle. Pick the state with the minimum final metric; ties go to the lowest index.
  - TRACE: 8 cycles, walking backward. The decoded bit at each step is the MSB of the current state; fill data_o from bit 0 up to bit 7.
  - OUT: data_o updated, valid_o=1 for exactly one cycle. Next cycle: IDLE, busy_o=0.
- Latency and timing:
  - dvalid_i accepted at cycle 0 -> valid_o at cycle 19 -> busy_o low at cycle 20.
  - A new frame may be accepted on the first cycle busy_o=0.
- Boundary conditions:
  - dvalid_i while busy_o=1 is ignored, with no queuing.
  - dvalid_i held high for several idle cycles starts exactly one frame.
  - Reset mid-frame: no valid_o is produced.
- Error-free frames must decode exactly. Any single channel-bit error in symbols 0..5 must also decode correctly.

Optional Feature:
Macro: VITERBI_PM_OUT_EN.
- Defined: adds output pm_o [PM_WIDTH-1:0]. It carries the winning final path metric, which equals the number of corrected channel-bit errors (hard decision). It is updated together with data_o, and reset value is 0.
- Undefined: the port and its register are absent; all other behaviour is identical.

Test Plan:
- Reset held 10 cycles, then released -> data_o=0x00, valid_o=0, busy_o=0. data_i=0x0000 strobed -> valid_o exactly 19 cycles later with data_o=0x00.
- data_i=0x3888 (encoding of 0x55) -> data_o=0x55. Then data_i=0xDAAA (encoding of 0xFF) -> data_o=0xFF, one valid_o pulse each.
- Sequence 0x55, 0xAB, then 5 random bytes, each software-encoded from state 00 and sent after busy_o=0 -> outputs in order, all matching; valid_o count equals frame count.
- data_i=0xB888 (0x3888 with bit 15 flipped) -> data_o=0x55; pm_o=1 when VITERBI_PM_OUT_EN is defined.
- Second dvalid_i with data_i=0xDAAA pulsed while busy_o=1 after a 0x3888 frame -> only one valid_o, data_o=0x55.
- rst_n asserted 5 cycles after a strobe -> no valid_o, busy_o=0 the cycle after reset. A fresh 0x3888 frame then decodes to 0x55.
